// File: rtl/simplebus_mem_arbiter_if.sv
// Bus bundle for the simple-bus memory arbiter: iBus/dBus core side plus the shared memory port.
// slave = arbiter view, master = environment (cores + memory) view.
interface simplebus_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              iBus_cmd_valid;
  logic              iBus_cmd_ready;
  logic [ADDR_W-1:0] iBus_cmd_payload_pc;
  logic              iBus_rsp_valid;
  logic [31:0]       iBus_rsp_payload_inst;
  logic              dBus_cmd_valid;
  logic              dBus_cmd_ready;
  logic              dBus_cmd_payload_wr;
  logic [ADDR_W-1:0] dBus_cmd_payload_address;
  logic [31:0]       dBus_cmd_payload_data;
  logic [1:0]        dBus_cmd_payload_size;
  logic              dBus_rsp_ready;
  logic [31:0]       dBus_rsp_data;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_wr;
  logic [ADDR_W-1:0] mem_cmd_address;
  logic [31:0]       mem_cmd_data;
  logic [3:0]        mem_cmd_mask;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              err_unexpected_rsp;

  modport slave (
    input  iBus_cmd_valid, iBus_cmd_payload_pc,
    input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
    input  dBus_cmd_payload_data, dBus_cmd_payload_size,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_inst,
    output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data,
    output mem_cmd_valid, mem_cmd_wr, mem_cmd_address, mem_cmd_data, mem_cmd_mask,
    output err_unexpected_rsp
  );

  modport master (
    output iBus_cmd_valid, iBus_cmd_payload_pc,
    output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
    output dBus_cmd_payload_data, dBus_cmd_payload_size,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_inst,
    input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data,
    input  mem_cmd_valid, mem_cmd_wr, mem_cmd_address, mem_cmd_data, mem_cmd_mask,
    input  err_unexpected_rsp
  );
endinterface

// File: rtl/simplebus_mem_arbiter.sv
// Shares one in-order memory port between iBus and dBus; routes read responses via a source-ID FIFO.
// Optional SIMPLEBUS_ARB_ROUND_ROBIN_EN: alternate grants when both masters request.
//
// state     | meaning
// ST_OPEN   | no stalled command, grant follows current valids
// ST_HOLD_I | iBus command stalled by memory, grant frozen to iBus
// ST_HOLD_D | dBus command stalled by memory, grant frozen to dBus
module simplebus_mem_arbiter #(
  parameter int PENDING_MAX = 4,
  parameter int ADDR_W      = 32
) (
  input logic                    clk,
  input logic                    reset,
  simplebus_mem_arbiter_if.slave bus
);
  localparam int PTR_W = (PENDING_MAX > 1) ? $clog2(PENDING_MAX) : 1;
  localparam int CNT_W = $clog2(PENDING_MAX + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PENDING_MAX);

  typedef enum logic [1:0] {ST_OPEN = 2'd0, ST_HOLD_I = 2'd1, ST_HOLD_D = 2'd2} state_e;
  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  state_e                 state_q, state_d;
  src_e                   gnt;
  logic [PENDING_MAX-1:0] src_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;
  logic                   cmd_rd, block, req, accept, push, pop, unexpected;
  logic [3:0]             d_base, d_mask;
  logic [ADDR_W-1:0]      cmd_addr;
`ifdef SIMPLEBUS_ARB_ROUND_ROBIN_EN
  src_e                   last_gnt_q, last_gnt_d;
`endif

  always_comb begin
    gnt     = SRC_I;
    state_d = ST_OPEN;
    unique case (state_q)
      ST_HOLD_I: gnt = SRC_I;
      ST_HOLD_D: gnt = SRC_D;
      default: begin
`ifdef SIMPLEBUS_ARB_ROUND_ROBIN_EN
        if (bus.dBus_cmd_valid && bus.iBus_cmd_valid)
          gnt = (last_gnt_q == SRC_I) ? SRC_D : SRC_I;
        else
          gnt = bus.dBus_cmd_valid ? SRC_D : SRC_I;
`else
        gnt = bus.dBus_cmd_valid ? SRC_D : SRC_I;
`endif
      end
    endcase
    // A stalled offer freezes the grant until memory takes it.
    if (bus.mem_cmd_valid && !bus.mem_cmd_ready)
      state_d = (gnt == SRC_D) ? ST_HOLD_D : ST_HOLD_I;
  end

  always_comb begin
    unique case (bus.dBus_cmd_payload_size)
      2'd0:    d_base = 4'h1;
      2'd1:    d_base = 4'h3;
      default: d_base = 4'hF;
    endcase
    d_mask = (bus.dBus_cmd_payload_size == 2'd3) ? 4'hF
                                                 : d_base << bus.dBus_cmd_payload_address[1:0];
  end

  assign cmd_rd   = (gnt == SRC_I) || !bus.dBus_cmd_payload_wr;
  assign block    = (count_q == FULL) && cmd_rd;
  assign req      = (gnt == SRC_D) ? bus.dBus_cmd_valid : bus.iBus_cmd_valid;
  assign cmd_addr = (gnt == SRC_D) ? bus.dBus_cmd_payload_address : bus.iBus_cmd_payload_pc;

  assign bus.mem_cmd_valid   = !reset && req && !block;
  assign bus.iBus_cmd_ready  = !reset && (gnt == SRC_I) && bus.mem_cmd_ready && !block;
  assign bus.dBus_cmd_ready  = !reset && (gnt == SRC_D) && bus.mem_cmd_ready && !block;
  assign bus.mem_cmd_wr      = (gnt == SRC_D) && bus.dBus_cmd_payload_wr;
  assign bus.mem_cmd_address = cmd_addr;
  assign bus.mem_cmd_data    = bus.dBus_cmd_payload_data;
  assign bus.mem_cmd_mask    = (gnt == SRC_D) ? d_mask : 4'hF;

  assign accept     = bus.mem_cmd_valid && bus.mem_cmd_ready;
  assign push       = accept && cmd_rd;
  assign pop        = !reset && bus.mem_rsp_valid && (count_q != '0);
  assign unexpected = !reset && bus.mem_rsp_valid && (count_q == '0);

  assign bus.iBus_rsp_valid        = pop && !src_q[rd_ptr_q];
  assign bus.dBus_rsp_ready        = pop && src_q[rd_ptr_q];
  assign bus.iBus_rsp_payload_inst = bus.mem_rsp_data;
  assign bus.dBus_rsp_data         = bus.mem_rsp_data;
  assign bus.err_unexpected_rsp    = err_q;

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  assign err_d   = err_q || unexpected;
`ifdef SIMPLEBUS_ARB_ROUND_ROBIN_EN
  assign last_gnt_d = accept ? gnt : last_gnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OPEN;
      src_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
`ifdef SIMPLEBUS_ARB_ROUND_ROBIN_EN
      last_gnt_q <= SRC_I;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        src_q[wr_ptr_q] <= (gnt == SRC_D);
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef SIMPLEBUS_ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_simplebus_mem_arbiter.sv
// Self-checking bench for simplebus_mem_arbiter: directed scenarios then randomized traffic
// against a queue-based reference model of the arbitration and response-routing rules.
module tb_simplebus_mem_arbiter;
  localparam int PMAX = 4;
`ifdef SIMPLEBUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simplebus_mem_arbiter_if #(.ADDR_W(32)) bus ();
  simplebus_mem_arbiter #(.PENDING_MAX(PMAX), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model: source of each outstanding read (1 = dBus), plus memory read data
  bit          srcq[$];
  logic [31:0] memq[$];
  bit lock_m, lock_gnt_m, last_m, err_m;
  bit hs_o, hs_gd_o;

  logic        obs_mcv, obs_wr, obs_ir, obs_dr, obs_irsp, obs_drsp, obs_err;
  logic [3:0]  obs_mask;
  logic [31:0] obs_addr, obs_irdata, obs_drdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; checks mid-cycle, then advances one clock.
  task automatic step();
    bit gd, rd, blk, mv, pop, unexp, hs, head;
    int m;
    logic [3:0] msk;
    #4;
    obs_mcv = bus.mem_cmd_valid;   obs_wr = bus.mem_cmd_wr;
    obs_ir  = bus.iBus_cmd_ready;  obs_dr = bus.dBus_cmd_ready;
    obs_irsp = bus.iBus_rsp_valid; obs_drsp = bus.dBus_rsp_ready;
    obs_err = bus.err_unexpected_rsp; obs_mask = bus.mem_cmd_mask;
    obs_addr = bus.mem_cmd_address;
    obs_irdata = bus.iBus_rsp_payload_inst; obs_drdata = bus.dBus_rsp_data;
    if (reset) begin
      chk("rst_mcv", obs_mcv, 0);
      chk("rst_iready", obs_ir, 0);
      chk("rst_dready", obs_dr, 0);
      chk("rst_irsp", obs_irsp, 0);
      chk("rst_drsp", obs_drsp, 0);
      hs_o = 0;
      @(posedge clk);
      srcq.delete(); lock_m = 0; last_m = 0; err_m = 0;
    end else begin
      if (lock_m) gd = lock_gnt_m;
      else if (bus.dBus_cmd_valid && bus.iBus_cmd_valid) gd = RR ? !last_m : 1'b1;
      else gd = bus.dBus_cmd_valid;
      rd  = gd ? !bus.dBus_cmd_payload_wr : 1'b1;
      blk = rd && (srcq.size() == PMAX);
      mv  = (gd ? bus.dBus_cmd_valid : bus.iBus_cmd_valid) && !blk;
      chk("mem_cmd_valid", obs_mcv, mv);
      chk("iBus_cmd_ready", obs_ir, !gd && bus.mem_cmd_ready && !blk);
      chk("dBus_cmd_ready", obs_dr, gd && bus.mem_cmd_ready && !blk);
      if (mv) begin
        chk("mem_cmd_wr", obs_wr, gd && bus.dBus_cmd_payload_wr);
        chk("mem_cmd_address", obs_addr, gd ? bus.dBus_cmd_payload_address : bus.iBus_cmd_payload_pc);
        if (gd) chk("mem_cmd_data", bus.mem_cmd_data, bus.dBus_cmd_payload_data);
        if (!gd || bus.dBus_cmd_payload_size == 2'd3) msk = 4'hF;
        else begin
          m = ((1 << (1 << int'(bus.dBus_cmd_payload_size))) - 1) << int'(bus.dBus_cmd_payload_address[1:0]);
          msk = m[3:0];
        end
        chk("mem_cmd_mask", obs_mask, msk);
      end
      pop   = bus.mem_rsp_valid && (srcq.size() > 0);
      unexp = bus.mem_rsp_valid && (srcq.size() == 0);
      head  = pop ? srcq[0] : 1'b0;
      chk("iBus_rsp_valid", obs_irsp, pop && !head);
      chk("dBus_rsp_ready", obs_drsp, pop && head);
      if (pop) begin
        chk("iBus_rsp_inst", obs_irdata, bus.mem_rsp_data);
        chk("dBus_rsp_data", obs_drdata, bus.mem_rsp_data);
      end
      chk("err_unexpected_rsp", obs_err, err_m);
      hs = mv && bus.mem_cmd_ready;
      @(posedge clk);
      if (pop) begin
        void'(srcq.pop_front());
        if (memq.size() > 0) void'(memq.pop_front());
      end
      if (hs && rd) begin
        srcq.push_back(gd);
        memq.push_back($urandom);
      end
      if (hs) last_m = gd;
      lock_m = mv && !bus.mem_cmd_ready;
      lock_gnt_m = gd;
      if (unexp) err_m = 1;
      hs_o = hs; hs_gd_o = gd;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.iBus_cmd_valid = 0; bus.iBus_cmd_payload_pc = '0;
    bus.dBus_cmd_valid = 0; bus.dBus_cmd_payload_wr = 0; bus.dBus_cmd_payload_address = '0;
    bus.dBus_cmd_payload_data = '0; bus.dBus_cmd_payload_size = 2'd2;
    bus.mem_cmd_ready = 1; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
  endtask

  task automatic set_d(input bit wr, input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
    bus.dBus_cmd_valid = 1; bus.dBus_cmd_payload_wr = wr; bus.dBus_cmd_payload_address = addr;
    bus.dBus_cmd_payload_size = sz; bus.dBus_cmd_payload_data = data;
  endtask

  task automatic drain();
    bus.iBus_cmd_valid = 0; bus.dBus_cmd_valid = 0;
    for (int k = 0; k < 40 && srcq.size() > 0; k++) begin
      bus.mem_rsp_valid = 1;
      bus.mem_rsp_data  = (memq.size() > 0) ? memq[0] : 32'h0;
      step();
    end
    bus.mem_rsp_valid = 0;
  endtask

  task automatic rand_drive(input int rsp_pct, input int rdy_pct);
    if (hs_o && hs_gd_o)  bus.dBus_cmd_valid = 0;
    if (hs_o && !hs_gd_o) bus.iBus_cmd_valid = 0;
    if (!bus.iBus_cmd_valid && ($urandom % 100) < 40) begin
      bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = $urandom;
    end
    if (!bus.dBus_cmd_valid && ($urandom % 100) < 40)
      set_d(1'($urandom % 2), $urandom, (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3), $urandom);
    bus.mem_cmd_ready = ($urandom % 100) < rdy_pct;
    if (memq.size() > 0 && ($urandom % 100) < rsp_pct) begin
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = memq[0];
    end else begin
      bus.mem_rsp_valid = 0; bus.mem_rsp_data = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rsp_pct[3] = '{50, 15, 80};
    int rdy_pct[3] = '{70, 90, 40};
    idle_inputs();
    reset = 1;
    #1;
    step(); step();
    reset = 0;
    step();

    // single fetch, response two cycles after acceptance
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h100;
    step();
    chk("t1_mask", obs_mask, 4'hF);
    chk("t1_iready", obs_ir, 1);
    bus.iBus_cmd_valid = 0;
    step();
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h13;
    step();
    chk("t1_irsp", obs_irsp, 1);
    chk("t1_inst", obs_irdata, 32'h13);
    bus.mem_rsp_valid = 0;
    step();
    chk("t1_irsp_once", obs_irsp, 0);

    // byte write at offset 3
    set_d(1, 32'h203, 2'd0, 32'hAABBCCDD);
    step();
    chk("t2_mask", obs_mask, 4'b1000);
    chk("t2_wr", obs_wr, 1);
    bus.dBus_cmd_valid = 0;
    step();
    chk("t2_no_drsp", obs_drsp, 0);

    // both masters always valid
    reset = 1; step(); reset = 0;
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h400;
    set_d(1, 32'h500, 2'd2, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_dready", obs_dr, RR ? (k % 2 == 0) : 1'b1);
      chk("t3_iready", obs_ir, RR ? (k % 2 == 1) : 1'b0);
    end
    drain();

    // in-order routing I, D, I
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h10; step();
    bus.iBus_cmd_valid = 0; set_d(0, 32'h20, 2'd2, 32'h0); step();
    bus.dBus_cmd_valid = 0; bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h30; step();
    bus.iBus_cmd_valid = 0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h1; step();
    chk("t4_rsp1_i", obs_irsp, 1); chk("t4_rsp1_data", obs_irdata, 32'h1);
    bus.mem_rsp_data = 32'h2; step();
    chk("t4_rsp2_d", obs_drsp, 1); chk("t4_rsp2_i_off", obs_irsp, 0); chk("t4_rsp2_data", obs_drdata, 32'h2);
    bus.mem_rsp_data = 32'h3; step();
    chk("t4_rsp3_i", obs_irsp, 1); chk("t4_rsp3_data", obs_irdata, 32'h3);
    bus.mem_rsp_valid = 0;

    // memory stall with dBus pending, iBus joins
    set_d(0, 32'h44, 2'd1, 32'h0); bus.mem_cmd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h88; end
      step();
      chk("t5_hold_valid", obs_mcv, 1); chk("t5_hold_addr", obs_addr, 32'h44);
      chk("t5_hold_iready", obs_ir, 0);
    end
    bus.mem_cmd_ready = 1; step();
    chk("t5_d_accept", obs_dr, 1);
    bus.dBus_cmd_valid = 0; step();
    chk("t5_i_accept", obs_ir, 1); chk("t5_i_addr", obs_addr, 32'h88);
    bus.iBus_cmd_valid = 0;
    drain();

    // stalled iBus keeps the grant even when dBus arrives
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h90; bus.mem_cmd_ready = 0; step();
    set_d(0, 32'h94, 2'd2, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t5b_lock_addr", obs_addr, 32'h90); chk("t5b_lock_dready", obs_dr, 0);
    end
    bus.mem_cmd_ready = 1; step();
    chk("t5b_i_accept", obs_ir, 1);
    bus.iBus_cmd_valid = 0; step();
    chk("t5b_d_accept", obs_dr, 1);
    drain();

    // full FIFO: pop in the same cycle does not unblock a read
    for (int k = 0; k < PMAX; k++) begin
      set_d(0, 32'h1000 + 32'(4 * k), 2'd2, 32'h0); step();
    end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h55; step();
    chk("t6_blocked_ready", obs_dr, 0); chk("t6_blocked_valid", obs_mcv, 0);
    chk("t6_rsp_same_cycle", obs_drsp, 1);
    bus.mem_rsp_valid = 0; step();
    chk("t6_accept_next", obs_dr, 1);
    drain();
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h66; step();
    chk("t6_drop_i", obs_irsp, 0); chk("t6_drop_d", obs_drsp, 0);
    bus.mem_rsp_valid = 0; step();
    chk("t6_err_set", obs_err, 1);

    // reset discards outstanding reads; a late response is unexpected
    reset = 1; step(); reset = 0; step();
    chk("t7_err_clear", obs_err, 0);
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h200; step();
    bus.iBus_cmd_valid = 0;
    reset = 1; step(); step(); reset = 0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hDEAD; step();
    chk("t7_stale_irsp", obs_irsp, 0);
    bus.mem_rsp_valid = 0; step();
    chk("t7_err_set", obs_err, 1);
    memq.delete();

    reset = 1; step(); reset = 0;
    idle_inputs();
    hs_o = 0;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 1000; c++) begin
        rand_drive(rsp_pct[p], rdy_pct[p]);
        step();
      end
    bus.mem_cmd_ready = 1;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
